// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding,
// control-output bundle and the default register-file address width.
package pipe_hazard_ctrl_pkg;

  localparam int REG_FILE_ADDR_LEN = 3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MC_WAIT  = 2'd1,
    ST_BR_FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic pc_freeze;
    logic ifid_freeze;
    logic ifid_flush;
    logic idexe_bubble;
    logic idexe_freeze;
    logic mc_err;
  } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW comparator for the instruction in ID.
// HAZ_FORWARD_EN: only a load in EXE stalls; otherwise any EXE/MEM producer stalls.
module hazard_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);

  // Register 0 is hard-wired, so writes to it never create a dependency.
  function automatic logic raw_match(input logic [REG_ADDR_W-1:0] src,
                                     input logic                  used,
                                     input logic [REG_ADDR_W-1:0] dest,
                                     input logic                  wb_en);
    return used && wb_en && (src == dest) && (dest != '0);
  endfunction

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = raw_match(id_src1, id_src1_used, exe_dest, exe_wb_en) ||
                   raw_match(id_src2, id_src2_used, exe_dest, exe_wb_en);
  assign mem_hit = raw_match(id_src1, id_src1_used, mem_dest, mem_wb_en) ||
                   raw_match(id_src2, id_src2_used, mem_dest, mem_wb_en);

`ifdef HAZ_FORWARD_EN
  // Forwarding covers ALU results from EXE and everything in MEM.
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
  assign hazard = exe_hit && exe_mem_r_en;
`else
  logic unused_mem_r_en;
  assign unused_mem_r_en = exe_mem_r_en;
  assign hazard = exe_hit || mem_hit;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: freeze/flush/bubble
// controls, multi-cycle timeout and saturating statistics. Option: HAZ_FORWARD_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_FILE_ADDR_LEN,
  parameter int MC_TIMEOUT = 15,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  br_taken,
  input  logic                  mc_start,
  input  logic                  mc_done,
  output logic                  pc_freeze,
  output logic                  ifid_freeze,
  output logic                  ifid_flush,
  output logic                  idexe_bubble,
  output logic                  idexe_freeze,
  output logic                  mc_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [1:0]            state
);

  localparam int TMO_W = $clog2(MC_TIMEOUT + 1);

  // Multi-cycle handshake: mc_start is a level that stays high while the op
  // occupies EXE; mc_done is a one-cycle pulse marking the result valid. The
  // pipeline stays frozen up to and including the mc_done cycle.
  hz_state_t        state_q;
  logic [TMO_W-1:0] tmo_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;
  logic             hazard;
  logic             tmo_hit;
  hz_ctrl_t         ctrl;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .hazard       (hazard)
  );

  assign tmo_hit = (tmo_q == TMO_W'(MC_TIMEOUT));

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      ST_RUN: begin
        if (br_taken) begin
          ctrl.ifid_flush   = 1'b1;
          ctrl.idexe_bubble = 1'b1;
        end else if (mc_start) begin
          ctrl.pc_freeze    = 1'b1;
          ctrl.ifid_freeze  = 1'b1;
          ctrl.idexe_freeze = 1'b1;
        end else if (hazard) begin
          ctrl.pc_freeze    = 1'b1;
          ctrl.ifid_freeze  = 1'b1;
          ctrl.idexe_bubble = 1'b1;
        end
      end
      ST_MC_WAIT: begin
        // br_taken cannot come from EXE while the multi-cycle op owns it.
        ctrl.pc_freeze    = 1'b1;
        ctrl.ifid_freeze  = 1'b1;
        ctrl.idexe_freeze = 1'b1;
        ctrl.mc_err       = tmo_hit && !mc_done;
      end
      ST_BR_FLUSH: begin
        ctrl.ifid_flush = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (br_taken) begin
            state_q <= ST_BR_FLUSH;
          end else if (mc_start) begin
            state_q <= ST_MC_WAIT;
            tmo_q   <= '0;
          end
        end
        ST_MC_WAIT: begin
          if (mc_done || tmo_hit) begin
            state_q <= ST_RUN;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        ST_BR_FLUSH: state_q <= ST_RUN;
        default:     state_q <= ST_RUN;
      endcase

      if (ctrl.pc_freeze && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if ((state_q == ST_RUN) && br_taken && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign pc_freeze    = ctrl.pc_freeze;
  assign ifid_freeze  = ctrl.ifid_freeze;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idexe_bubble = ctrl.idexe_bubble;
  assign idexe_freeze = ctrl.idexe_freeze;
  assign mc_err       = ctrl.mc_err;
  assign stall_cnt    = stall_q;
  assign flush_cnt    = flush_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each driven cycle pushes its expected
// {stall_cnt, flush_cnt, state, controls} word; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int W = 16;
  // Control order: pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, idexe_freeze, mc_err
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_HAZ  = 6'b110100;
  localparam logic [5:0] C_BR   = 6'b001100;
  localparam logic [5:0] C_BRF  = 6'b001000;
  localparam logic [5:0] C_MC   = 6'b110010;
  localparam logic [5:0] C_ERR  = 6'b110011;
`ifdef HAZ_FORWARD_EN
  localparam logic [5:0] C_NOFWD = C_NONE;
`else
  localparam logic [5:0] C_NOFWD = C_HAZ;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_src1_used, id_src2_used, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       br_taken, mc_start, mc_done;
  logic       pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, idexe_freeze, mc_err;
  logic [3:0] stall_cnt, flush_cnt;
  logic [1:0] state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [3:0]   exp_stall = 4'd0;
  logic [3:0]   exp_flush = 4'd0;
  int           tests = 0;
  int           failed = 0;

  pipe_hazard_ctrl #(
    .REG_ADDR_W (3),
    .MC_TIMEOUT (15),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .exe_dest     (exe_dest),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .mem_dest     (mem_dest),
    .mem_wb_en    (mem_wb_en),
    .br_taken     (br_taken),
    .mc_start     (mc_start),
    .mc_done      (mc_done),
    .pc_freeze    (pc_freeze),
    .ifid_freeze  (ifid_freeze),
    .ifid_flush   (ifid_flush),
    .idexe_bubble (idexe_bubble),
    .idexe_freeze (idexe_freeze),
    .mc_err       (mc_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .state        (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    id_src1 = '0; id_src2 = '0; id_src1_used = 1'b0; id_src2_used = 1'b0;
    exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
    mem_dest = '0; mem_wb_en = 1'b0;
    br_taken = 1'b0; mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic load_use_on_src1(input logic [2:0] r);
    exe_dest = r; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
    id_src1 = r; id_src1_used = 1'b1;
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic step(input string name, input logic [1:0] st, input logic [5:0] ctl);
    exp_q.push_back({exp_stall, exp_flush, st, ctl});
    name_q.push_back(name);
    if (ctl[5] && exp_stall != 4'hF) exp_stall = exp_stall + 4'd1;
    if (st == 2'd0 && ctl == C_BR && exp_flush != 4'hF) exp_flush = exp_flush + 4'd1;
    if (rst) begin
      exp_stall = 4'd0;
      exp_flush = 4'd0;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_w;
      logic [W-1:0] act_w;
      string        nm;
      exp_w = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_w = {stall_cnt, flush_cnt, state,
               pc_freeze, ifid_freeze, ifid_flush, idexe_bubble, idexe_freeze, mc_err};
      tests = tests + 1;
      if (act_w !== exp_w) begin
        failed = failed + 1;
        $display("FAIL %s: got stall=%0d flush=%0d state=%0d ctl=%b, expected stall=%0d flush=%0d state=%0d ctl=%b",
                 nm, act_w[15:12], act_w[11:8], act_w[7:6], act_w[5:0],
                 exp_w[15:12], exp_w[11:8], exp_w[7:6], exp_w[5:0]);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step("reset_state", 2'd0, C_NONE);

    // Load-use: one stall; the producer then sits in MEM.
    load_use_on_src1(3'd3);
    step("load_use", 2'd0, C_HAZ);
    idle(); mem_dest = 3'd3; mem_wb_en = 1'b1; id_src1 = 3'd3; id_src1_used = 1'b1;
    step("load_in_mem", 2'd0, C_NOFWD);
    idle();
    step("after_load", 2'd0, C_NONE);

    // Boundary cases that must not stall.
    load_use_on_src1(3'd0); id_src2 = 3'd0; id_src2_used = 1'b1;
    step("zero_reg", 2'd0, C_NONE);
    idle(); load_use_on_src1(3'd4); id_src1_used = 1'b0;
    step("unused_src", 2'd0, C_NONE);

    // Non-load producers.
    idle(); exe_dest = 3'd6; exe_wb_en = 1'b1; id_src2 = 3'd6; id_src2_used = 1'b1;
    step("alu_in_exe", 2'd0, C_NOFWD);
    idle(); mem_dest = 3'd5; mem_wb_en = 1'b1; id_src2 = 3'd5; id_src2_used = 1'b1;
    step("mem_raw_1", 2'd0, C_NOFWD);
    step("mem_raw_2", 2'd0, C_NOFWD);
    mem_wb_en = 1'b0;
    step("mem_raw_nowb", 2'd0, C_NONE);

    // Branch beats a concurrent load-use hazard.
    idle(); load_use_on_src1(3'd3); br_taken = 1'b1;
    step("br_taken", 2'd0, C_BR);
    idle();
    step("br_flush", 2'd2, C_BRF);
    step("br_done", 2'd0, C_NONE);

    // Branch beats mc_start; br_taken in BR_FLUSH is not a new flush.
    br_taken = 1'b1; mc_start = 1'b1;
    step("br_over_mc", 2'd0, C_BR);
    mc_start = 1'b0;
    step("br_in_flush", 2'd2, C_BRF);
    idle();
    step("br2_done", 2'd0, C_NONE);

    // Multi-cycle op: four frozen cycles, branch ignored while waiting.
    mc_start = 1'b1;
    step("mc_enter", 2'd0, C_MC);
    br_taken = 1'b1;
    step("mc_br_ignored", 2'd1, C_MC);
    br_taken = 1'b0;
    step("mc_wait", 2'd1, C_MC);
    mc_done = 1'b1;
    step("mc_done", 2'd1, C_MC);
    idle();
    step("mc_resume", 2'd0, C_NONE);

    // Timeout: 15 plain wait cycles, then the mc_err cycle.
    mc_start = 1'b1;
    step("tmo_enter", 2'd0, C_MC);
    for (int i = 0; i < 15; i++) step("tmo_wait", 2'd1, C_MC);
    step("tmo_err", 2'd1, C_ERR);
    idle();
    step("tmo_resume", 2'd0, C_NONE);

    // mc_done at the expiry cycle wins over the timeout.
    mc_start = 1'b1;
    step("tmo2_enter", 2'd0, C_MC);
    for (int i = 0; i < 15; i++) step("tmo2_wait", 2'd1, C_MC);
    mc_done = 1'b1;
    step("tmo2_done_wins", 2'd1, C_MC);
    idle();
    step("tmo2_resume", 2'd0, C_NONE);

    // stall_cnt is saturated by now and must hold at 15.
    load_use_on_src1(3'd2);
    step("sat_stall", 2'd0, C_HAZ);
    idle();
    step("sat_hold", 2'd0, C_NONE);

    // Reset inside MC_WAIT.
    mc_start = 1'b1;
    step("rst_mc_enter", 2'd0, C_MC);
    step("rst_mc_wait", 2'd1, C_MC);
    rst = 1'b1;
    step("rst_mc_edge", 2'd1, C_MC);
    rst = 1'b0; idle();
    step("rst_mc_after", 2'd0, C_NONE);

    // Reset inside BR_FLUSH.
    br_taken = 1'b1;
    step("rst_br_enter", 2'd0, C_BR);
    br_taken = 1'b0; rst = 1'b1;
    step("rst_br_edge", 2'd2, C_BRF);
    rst = 1'b0;
    step("rst_br_after", 2'd0, C_NONE);

    // Counters restart cleanly after reset.
    load_use_on_src1(3'd7);
    step("post_rst_stall", 2'd0, C_HAZ);
    idle();
    step("post_rst_cnt", 2'd0, C_NONE);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests = tests + 1;
      failed = failed + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
